alu_issue_stage: RTL and testbench

Sequencing stage directly upstream of the 8-bit combinational ALU (ops ADD, SUB, AND, OR, ANDN; zero flag). It accepts operation commands over a valid/ready handshake and registers the operands and select onto the ALU inputs. It captures the ALU result and zero flag one cycle later and presents them on a valid/ready result port. It keeps an accumulator of the last result so that commands can chain, and counts completed operations.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_issue_stage_if.sv | 29 ++
 rtl/alu_issue_stage.sv | 92 +++++++++
 tb/tb_alu_issue_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, state and helper definitions for the ALU issue stage and its ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_LAST = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_illegal_op(input logic [2:0] sel);
        return sel > OP_LAST;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command and result handshake bundle of the ALU issue stage.
interface alu_issue_stage_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [2:0]        cmd_sel;
    logic              cmd_chain;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic              res_err;

    // master issues commands and consumes results; slave is the stage
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain, res_ready,
        input  cmd_ready, res_valid, res_data, res_zero, res_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain, res_ready,
        output cmd_ready, res_valid, res_data, res_zero, res_err
    );

endinterface

// File: rtl/alu_issue_stage.sv
// Registers commands onto an external ALU, captures its result one cycle later
// and offers it on a result handshake; keeps an accumulator for chained ops.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [2:0]        alu_sel_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic [7:0]        op_count_o
);

    state_t            state_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [2:0]        alu_sel_q;
    logic              err_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_zero_q;
    logic              res_err_q;
    logic [7:0]        op_count_q;

    logic              accept;
    logic [DATA_W-1:0] alu_a_d;
    logic              err_d;

    // Handshake flags are decoded straight from state so they can never overlap.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_err   = res_err_q;

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_sel_o  = alu_sel_q;
    assign op_count_o = op_count_q;

    assign accept  = bus.cmd_valid && (state_q == IDLE);
    assign alu_a_d = bus.cmd_chain ? acc_q : bus.cmd_a;
    assign err_d   = is_illegal_op(bus.cmd_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            err_q      <= 1'b0;
            acc_q      <= '0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            res_err_q  <= 1'b0;
            op_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q   <= alu_a_d;
                        alu_b_q   <= bus.cmd_b;
                        alu_sel_q <= bus.cmd_sel;
                        err_q     <= err_d;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal opcodes still go through the ALU, which returns 0.
                    res_data_q <= alu_result_i;
                    res_zero_q <= alu_zero_i;
                    res_err_q  <= err_q;
                    acc_q      <= alu_result_i;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        op_count_q <= op_count_q + 8'd1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench: directed vector table, hand sequences for hold/reset/wrap,
// and randomized ops against an arithmetic reference model.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] alu_a, alu_b, alu_result, op_count;
    logic [2:0] alu_sel;
    logic       alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_acc;
    logic [7:0] model_count;

    alu_issue_stage_if #(.DATA_W(8)) bus ();

    alu_issue_stage #(.DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_sel_o    (alu_sel),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .op_count_o   (op_count)
    );

    // Combinational ALU the stage drives
    always_comb begin
        alu_result = 8'h00;
        case (alu_sel)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_ANDN: alu_result = alu_a & ~alu_b;
            default: alu_result = 8'h00;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic       chain;
        int         hold;
        logic [7:0] exp_data;
        logic       exp_zero;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_alu(input int sel, input int a, input int b,
                                    output logic [7:0] r, output logic z, output logic e);
        int v;
        e = 1'b0;
        case (sel)
            0: v = a + b;
            1: v = a - b + 256;
            2: v = a & b;
            3: v = a | b;
            4: v = a & (255 - b);
            default: begin v = 0; e = 1'b1; end
        endcase
        r = 8'(v % 256);
        z = (r == 8'h00);
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                         input logic chain, input int hold, input bit use_tab,
                         input logic [7:0] t_data, input logic t_zero, input logic t_err);
        logic [7:0] eff_a, e_data;
        logic       e_zero, e_err;
        eff_a = chain ? model_acc : a;
        if (use_tab) begin
            e_data = t_data; e_zero = t_zero; e_err = t_err;
        end else begin
            ref_alu(int'(sel), int'(eff_a), int'(b), e_data, e_zero, e_err);
        end

        @(negedge clk);
        check("idle_cmd_ready", bus.cmd_ready, 1);
        check("idle_res_valid", bus.res_valid, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sel   = sel;
        bus.cmd_chain = chain;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("exec_alu_a", alu_a, eff_a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_sel", alu_sel, sel);
        check("exec_cmd_ready", bus.cmd_ready, 0);
        check("exec_res_valid", bus.res_valid, 0);
        @(posedge clk); #1;
        check("done_res_valid", bus.res_valid, 1);
        check("done_cmd_ready", bus.cmd_ready, 0);
        check("res_data", bus.res_data, e_data);
        check("res_zero", bus.res_zero, e_zero);
        check("res_err", bus.res_err, e_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = ~a;
            bus.cmd_chain = 1'b0;
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            check("hold_res_valid", bus.res_valid, 1);
            check("hold_cmd_ready", bus.cmd_ready, 0);
            check("hold_res_data", bus.res_data, e_data);
            check("hold_res_zero", bus.res_zero, e_zero);
            check("hold_res_err", bus.res_err, e_err);
            check("hold_op_count", op_count, model_count);
            check("hold_alu_a", alu_a, eff_a);
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        model_count = model_count + 8'd1;
        model_acc   = e_data;
        check("hs_op_count", op_count, model_count);
        check("hs_res_valid", bus.res_valid, 0);
        check("hs_cmd_ready", bus.cmd_ready, 1);
        $display("op a=%02h b=%02h sel=%0d chain=%0d hold=%0d -> data=%02h zero=%0d err=%0d count=%0d",
                 a, b, sel, chain, hold, bus.res_data, bus.res_zero, bus.res_err, op_count);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [2:0] rs;
        logic       rc;

        vecs[0] = '{8'h05, 8'h03, OP_ADD,  1'b0, 0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h08, OP_SUB,  1'b1, 0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 8'h08, OP_SUB,  1'b0, 0, 8'hFB, 1'b0, 1'b0};
        vecs[3] = '{8'hCC, 8'hAA, OP_ANDN, 1'b0, 0, 8'h44, 1'b0, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 3'b111,  1'b0, 0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hF0, 8'h0F, OP_OR,   1'b0, 4, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h0F, OP_AND,  1'b1, 0, 8'h0F, 1'b0, 1'b0};
        vecs[7] = '{8'h10, 8'h05, OP_ADD,  1'b1, 2, 8'h14, 1'b0, 1'b0};

        model_acc     = 8'h00;
        model_count   = 8'h00;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.cmd_sel   = 3'b000;
        bus.cmd_chain = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_res_data", bus.res_data, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].chain, vecs[i].hold, 1'b1,
                  vecs[i].exp_data, vecs[i].exp_zero, vecs[i].exp_err);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 3'($urandom_range(0, 7));
            rc = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, rc, int'($urandom_range(0, 2)), 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Reset asserted while an op is in EXEC
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'h5A;
        bus.cmd_b     = 8'h21;
        bus.cmd_sel   = OP_ADD;
        bus.cmd_chain = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("pre_rst_exec", bus.cmd_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_res_valid", bus.res_valid, 0);
        check("midrst_cmd_ready", bus.cmd_ready, 1);
        check("midrst_op_count", op_count, 0);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_alu_b", alu_b, 0);
        check("midrst_res_data", bus.res_data, 0);
        @(negedge clk);
        rst = 1'b0;
        model_acc   = 8'h00;
        model_count = 8'h00;
        $display("reset asserted mid-EXEC, op discarded");
        // Chained ADD with b=0 exposes the cleared accumulator
        do_op(8'h77, 8'h00, OP_ADD, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 1; i < 256; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 3'($urandom_range(0, 4));
            do_op(ra, rb, rs, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        check("op_count_wrap", op_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
